// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two masters (CPU, DMA), the arbiter and the single-port RAM.
interface mem_arbiter_if;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  // CPU master (master 0)
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_we;
  logic          cpu_be;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  // DMA master (master 1)
  logic          dma_req;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_we;
  logic          dma_be;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;

  // RAM side
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic          ram_re;
  logic          ram_be;
  logic [DW-1:0] ram_rdata;

  // Status
  logic          busy;
  logic          owner;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_we, cpu_be,
    output cpu_ack, cpu_rdata,
    input  dma_req, dma_addr, dma_wdata, dma_we, dma_be,
    output dma_ack, dma_rdata,
    output ram_addr, ram_wdata, ram_we, ram_re, ram_be,
    input  ram_rdata,
    output busy, owner
  );

  // Masters plus RAM model side
  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cpu_we, cpu_be,
    input  cpu_ack, cpu_rdata,
    output dma_req, dma_addr, dma_wdata, dma_we, dma_be,
    input  dma_ack, dma_rdata,
    input  ram_addr, ram_wdata, ram_we, ram_re, ram_be,
    output ram_rdata,
    input  busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the shared single-port 16-bit RAM: CPU (master 0) and DMA (master 1).
// Fixed CPU priority with starvation guard (ARB_MODE 0) or round-robin (ARB_MODE 1).
module mem_arbiter #(
  parameter int unsigned WAIT_STATES  = 1,
  parameter int unsigned ARB_MODE     = 0,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 16;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we;
    logic          be;
  } xfer_t;

  state_t        state_q, state_d;
  xfer_t         xfer_q, xfer_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          rr_dma_q, rr_dma_d;
  logic          owner_q, owner_d;
  logic          ram_re_q, ram_re_d;
  logic          ram_we_q, ram_we_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          dma_ack_q, dma_ack_d;
  logic          busy_q, busy_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;

  logic          grant_dma_c;
  xfer_t         sel_c;

  // Pick the winner among the current requesters and its payload
  always_comb begin
    grant_dma_c = 1'b0;
    if (bus.cpu_req && bus.dma_req) begin
      if (ARB_MODE != 0) grant_dma_c = rr_dma_q;
      else               grant_dma_c = (starve_q == CW'(STARVE_LIMIT));
    end else begin
      grant_dma_c = bus.dma_req;
    end
    sel_c = grant_dma_c ? '{addr: bus.dma_addr, wdata: bus.dma_wdata, we: bus.dma_we, be: bus.dma_be}
                        : '{addr: bus.cpu_addr, wdata: bus.cpu_wdata, we: bus.cpu_we, be: bus.cpu_be};
  end

  // Next-state and next-output logic; strobes and acks are computed one cycle ahead
  always_comb begin
    state_d     = state_q;
    xfer_d      = xfer_q;
    wait_d      = wait_q;
    starve_d    = starve_q;
    rr_dma_d    = rr_dma_q;
    owner_d     = owner_q;
    ram_re_d    = 1'b0;
    ram_we_d    = 1'b0;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    busy_d      = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;

    case (state_q)
      IDLE: begin
        if (bus.cpu_req || bus.dma_req) begin
          state_d  = ACCESS;
          xfer_d   = sel_c;
          owner_d  = grant_dma_c;
          wait_d   = CW'(WAIT_STATES);
          rr_dma_d = ~grant_dma_c;
          busy_d   = 1'b1;
          ram_re_d = ~sel_c.we;
          ram_we_d = sel_c.we;
          if (grant_dma_c || !bus.dma_req) begin
            starve_d = '0;
          end else if (starve_q != CW'(STARVE_LIMIT)) begin
            starve_d = starve_q + CW'(1);
          end
        end
      end
      ACCESS: begin
        busy_d = 1'b1;
        if (wait_q == '0) begin
          state_d   = DONE;
          cpu_ack_d = ~owner_q;
          dma_ack_d = owner_q;
          if (!xfer_q.we) begin
            if (owner_q) dma_rdata_d = bus.ram_rdata;
            else         cpu_rdata_d = bus.ram_rdata;
          end
        end else begin
          wait_d   = wait_q - CW'(1);
          ram_re_d = ~xfer_q.we;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      xfer_q      <= '0;
      wait_q      <= '0;
      starve_q    <= '0;
      rr_dma_q    <= 1'b0;
      owner_q     <= 1'b0;
      ram_re_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      xfer_q      <= xfer_d;
      wait_q      <= wait_d;
      starve_q    <= starve_d;
      rr_dma_q    <= rr_dma_d;
      owner_q     <= owner_d;
      ram_re_q    <= ram_re_d;
      ram_we_q    <= ram_we_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      busy_q      <= busy_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign bus.ram_addr  = xfer_q.addr;
  assign bus.ram_wdata = xfer_q.wdata;
  assign bus.ram_be    = xfer_q.be;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_re    = ram_re_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dma_ack   = dma_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.busy      = busy_q;
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: two instances (priority/WS=1 and round-robin/WS=0)
// checked every cycle against a transaction-timing reference model.
module tb_mem_arbiter;
  localparam int WS_A = 1, MODE_A = 0, LIM_A = 8;
  localparam int WS_B = 0, MODE_B = 1, LIM_B = 3;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus_a();
  mem_arbiter_if bus_b();

  mem_arbiter #(.WAIT_STATES(WS_A), .ARB_MODE(MODE_A), .STARVE_LIMIT(LIM_A)) u_dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  mem_arbiter #(.WAIT_STATES(WS_B), .ARB_MODE(MODE_B), .STARVE_LIMIT(LIM_B)) u_dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  // RAM contents as a pure function of address; 0x0010 holds 0xBEEF
  function automatic logic [15:0] ram_fn(input logic [15:0] a);
    if (a == 16'h0010) return 16'hBEEF;
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  // Master stimulus, indexed [instance][master], master 0 = CPU, 1 = DMA
  logic        req    [2][2];
  logic [15:0] s_addr [2][2];
  logic [15:0] s_wdata[2][2];
  logic        s_we   [2][2];
  logic        s_be   [2][2];
  bit          pend   [2][2];

  assign bus_a.cpu_req = req[0][0];  assign bus_a.dma_req = req[0][1];
  assign bus_a.cpu_addr = s_addr[0][0];  assign bus_a.dma_addr = s_addr[0][1];
  assign bus_a.cpu_wdata = s_wdata[0][0];  assign bus_a.dma_wdata = s_wdata[0][1];
  assign bus_a.cpu_we = s_we[0][0];  assign bus_a.dma_we = s_we[0][1];
  assign bus_a.cpu_be = s_be[0][0];  assign bus_a.dma_be = s_be[0][1];
  assign bus_a.ram_rdata = ram_fn(bus_a.ram_addr);

  assign bus_b.cpu_req = req[1][0];  assign bus_b.dma_req = req[1][1];
  assign bus_b.cpu_addr = s_addr[1][0];  assign bus_b.dma_addr = s_addr[1][1];
  assign bus_b.cpu_wdata = s_wdata[1][0];  assign bus_b.dma_wdata = s_wdata[1][1];
  assign bus_b.cpu_we = s_we[1][0];  assign bus_b.dma_we = s_we[1][1];
  assign bus_b.cpu_be = s_be[1][0];  assign bus_b.dma_be = s_be[1][1];
  assign bus_b.ram_rdata = ram_fn(bus_b.ram_addr);

  // Reference model state per instance: one transaction in flight, timed by its grant cycle
  int          ws[2], mode[2], lim[2];
  bit          act[2];
  int          g[2];
  int          free_at[2];
  bit          m_ow[2], m_we[2], m_be[2];
  logic [15:0] m_addr[2], m_wdata[2], m_crd[2], m_drd[2];
  int          starve[2];
  bit          last_dma[2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset(input int k, input int at);
    act[k] = 1'b0;  free_at[k] = at;
    m_ow[k] = 1'b0;  m_we[k] = 1'b0;  m_be[k] = 1'b0;
    m_addr[k] = '0;  m_wdata[k] = '0;  m_crd[k] = '0;  m_drd[k] = '0;
    starve[k] = 0;  last_dma[k] = 1'b1;
    for (int m = 0; m < 2; m++) begin
      pend[k][m] = 1'b0;  req[k][m] = 1'b0;
    end
  endtask

  function automatic logic [63:0] obs_ctl(input int k);
    if (k == 0) return 64'({bus_a.busy, bus_a.ram_re, bus_a.ram_we, bus_a.cpu_ack, bus_a.dma_ack, bus_a.owner});
    return 64'({bus_b.busy, bus_b.ram_re, bus_b.ram_we, bus_b.cpu_ack, bus_b.dma_ack, bus_b.owner});
  endfunction

  function automatic logic [63:0] obs_bus(input int k);
    if (k == 0) return 64'({bus_a.ram_addr, bus_a.ram_wdata, bus_a.ram_be});
    return 64'({bus_b.ram_addr, bus_b.ram_wdata, bus_b.ram_be});
  endfunction

  function automatic logic [63:0] obs_rd(input int k);
    if (k == 0) return 64'({bus_a.cpu_rdata, bus_a.dma_rdata});
    return 64'({bus_b.cpu_rdata, bus_b.dma_rdata});
  endfunction

  initial begin
    bit e_busy, e_re, e_we, e_ack, win, rst_next;
    int rate;
    string nm;
    ws[0] = WS_A;  mode[0] = MODE_A;  lim[0] = LIM_A;
    ws[1] = WS_B;  mode[1] = MODE_B;  lim[1] = LIM_B;
    for (int k = 0; k < 2; k++) begin
      model_reset(k, 0);
      for (int m = 0; m < 2; m++) begin
        s_addr[k][m] = '0;  s_wdata[k][m] = '0;  s_we[k][m] = 1'b0;  s_be[k][m] = 1'b0;
      end
    end

    for (int t = 0; t < NCYC; t++) begin
      @(negedge clk);
      cyc = t;

      // Expected outputs for cycle t
      for (int k = 0; k < 2; k++) begin
        nm = (k == 0) ? "A" : "B";
        e_busy = 1'b0;  e_re = 1'b0;  e_we = 1'b0;  e_ack = 1'b0;
        if (act[k] && t >= g[k] + 1 && t <= g[k] + ws[k] + 2) begin
          e_busy = 1'b1;
          e_re   = (t <= g[k] + ws[k] + 1) && !m_we[k];
          e_we   = (t == g[k] + 1) && m_we[k];
          e_ack  = (t == g[k] + ws[k] + 2);
        end
        if (e_ack) begin
          if (!m_we[k]) begin
            if (m_ow[k]) m_drd[k] = ram_fn(m_addr[k]);
            else         m_crd[k] = ram_fn(m_addr[k]);
          end
          pend[k][m_ow[k]] = 1'b0;
          req[k][m_ow[k]]  = 1'b0;
          act[k] = 1'b0;
        end
        check({nm, ".ctl{busy,re,we,cack,dack,owner}"}, obs_ctl(k),
              64'({e_busy, e_re, e_we, e_ack && !m_ow[k], e_ack && m_ow[k], m_ow[k]}));
        check({nm, ".ram{addr,wdata,be}"}, obs_bus(k), 64'({m_addr[k], m_wdata[k], m_be[k]}));
        check({nm, ".rdata{cpu,dma}"}, obs_rd(k), 64'({m_crd[k], m_drd[k]}));
      end

      // Reset for the coming edge: initial pulse plus occasional random aborts
      rst_next = (t < 2) || ($urandom_range(0, 249) == 0);
      reset = rst_next;
      rate = (t < 1000) ? 30 : (t < 2000) ? 100 : 60;

      for (int k = 0; k < 2; k++) begin
        if (rst_next) begin
          model_reset(k, t + 1);
          continue;
        end
        for (int m = 0; m < 2; m++) begin
          if (!pend[k][m]) begin
            if ($urandom_range(0, 99) < rate) begin
              pend[k][m]    = 1'b1;
              req[k][m]     = 1'b1;
              s_addr[k][m]  = ($urandom_range(0, 3) == 0) ? 16'h0010 : 16'($urandom);
              s_wdata[k][m] = 16'($urandom);
              s_we[k][m]    = 1'($urandom_range(0, 1));
              s_be[k][m]    = 1'($urandom_range(0, 1));
            end
          end else if (act[k] && m_ow[k] == 1'(m) && req[k][m] && $urandom_range(0, 9) == 0) begin
            // Requester gives up mid-access; the access must still complete
            req[k][m] = 1'b0;
          end
        end
        // Grant decision at the coming edge
        if (t >= free_at[k] && (req[k][0] || req[k][1])) begin
          if (req[k][0] && req[k][1]) begin
            if (mode[k] == 1) win = !last_dma[k];
            else              win = (starve[k] == lim[k]);
          end else begin
            win = req[k][1];
          end
          if (win || !req[k][1]) starve[k] = 0;
          else if (starve[k] < lim[k]) starve[k] = starve[k] + 1;
          last_dma[k] = win;
          act[k] = 1'b1;  g[k] = t;  free_at[k] = t + ws[k] + 3;
          m_ow[k] = win;
          m_addr[k]  = s_addr[k][win];
          m_wdata[k] = s_wdata[k][win];
          m_we[k]    = s_we[k][win];
          m_be[k]    = s_be[k][win];
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
